taus_113: RTL and testbench



---
 rtl/taus_pkg.sv | 43 ++++
 rtl/taus_component.sv | 45 ++++
 rtl/taus_113.sv | 81 ++++++++
 tb/tb_taus_113.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/taus_pkg.sv
// Shared constants for the LFSR113 combined Tausworthe generator.
// Holds the default seed, the per-component (q, s, k) shift triplets,
// the per-component keep masks, and the one-step recurrence helper.
package taus_pkg;

    localparam logic [31:0] SEED_DEFAULT = 32'd12345;

    // Component 1
    localparam int unsigned Q1 = 6;
    localparam int unsigned S1 = 13;
    localparam int unsigned K1 = 18;
    localparam logic [31:0] MASK1 = 32'hFFFFFFFE;

    // Component 2
    localparam int unsigned Q2 = 2;
    localparam int unsigned S2 = 27;
    localparam int unsigned K2 = 2;
    localparam logic [31:0] MASK2 = 32'hFFFFFFF8;

    // Component 3
    localparam int unsigned Q3 = 13;
    localparam int unsigned S3 = 21;
    localparam int unsigned K3 = 7;
    localparam logic [31:0] MASK3 = 32'hFFFFFFF0;

    // Component 4
    localparam int unsigned Q4 = 3;
    localparam int unsigned S4 = 12;
    localparam int unsigned K4 = 13;
    localparam logic [31:0] MASK4 = 32'hFFFFFF80;

    // One Tausworthe step; all shifts are logical and bits shifted out are lost.
    function automatic logic [31:0] taus_next(input logic [31:0] z,
                                              input int unsigned q,
                                              input int unsigned s,
                                              input int unsigned k,
                                              input logic [31:0] mask);
        logic [31:0] b;
        b = ((z << q) ^ z) >> s;
        return ((z & mask) << k) ^ b;
    endfunction

endpackage

// File: rtl/taus_component.sv
// One 32-bit Tausworthe component generator.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset, loads INIT
//   load     load strobe, loads load_val (lower priority than reset)
//   load_val value loaded when load=1
//   state    current component state
// With neither reset nor load asserted the state advances one step per clock.
module taus_component
    import taus_pkg::*;
#(
    parameter int unsigned Q    = Q1,
    parameter int unsigned S    = S1,
    parameter int unsigned K    = K1,
    parameter logic [31:0] MASK = MASK1,
    parameter logic [31:0] INIT = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = taus_next(state_q, Q, S, K, MASK);
        if (load) begin
            state_d = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/taus_113.sv
// L'Ecuyer LFSR113 combined Tausworthe uniform random number generator.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (restores all seeds)
//   seed     new S1 value, taken when re_seed=1
//   re_seed  reseed strobe, level-sampled each rising edge
//   rnd      current random word, S1^S2^S3^S4
// S2..S4 always reload their fixed seeds on a reseed so the stream after a
// reseed depends only on the supplied seed.
module taus_113
    import taus_pkg::*;
#(
    parameter logic [31:0] SEED2         = 32'd12345,
    parameter logic [31:0] SEED3         = 32'd12345,
    parameter logic [31:0] SEED4         = 32'd12345,
    parameter logic [31:0] SEED1_DEFAULT = 32'd12345
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    input  logic        re_seed,
    output logic [31:0] rnd
);

    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic [31:0] s4;
    logic [31:0] s1_load;

    // A seed of 0 or 1 would clear S1 under the mask and lock it at zero.
    always_comb begin
        s1_load = seed;
        if (seed[31:1] == 31'd0) begin
            s1_load = SEED1_DEFAULT;
        end
    end

    taus_component #(
        .Q(Q1), .S(S1), .K(K1), .MASK(MASK1), .INIT(SEED1_DEFAULT)
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (re_seed),
        .load_val (s1_load),
        .state    (s1)
    );

    taus_component #(
        .Q(Q2), .S(S2), .K(K2), .MASK(MASK2), .INIT(SEED2)
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (re_seed),
        .load_val (SEED2),
        .state    (s2)
    );

    taus_component #(
        .Q(Q3), .S(S3), .K(K3), .MASK(MASK3), .INIT(SEED3)
    ) u_s3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (re_seed),
        .load_val (SEED3),
        .state    (s3)
    );

    taus_component #(
        .Q(Q4), .S(S4), .K(K4), .MASK(MASK4), .INIT(SEED4)
    ) u_s4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (re_seed),
        .load_val (SEED4),
        .state    (s4)
    );

    assign rnd = s1 ^ s2 ^ s3 ^ s4;

endmodule

// File: tb/tb_taus_113.sv
// Directed bench for taus_113: reset, reseed, hold, illegal seeds, restart.
module tb_taus_113;

    logic        clk;
    logic        rst_n;
    logic [31:0] seed;
    logic        re_seed;
    logic [31:0] rnd;

    int checks = 0;
    int errors = 0;

    // Reference generator state
    logic [31:0] z1, z2, z3, z4;
    logic [31:0] seq_rst [10];
    logic [31:0] seq_db  [10];

    taus_113 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (seed),
        .re_seed (re_seed),
        .rnd     (rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_seed(input logic [31:0] s);
        z1 = (s < 32'd2) ? 32'd12345 : s;
        z2 = 32'd12345;
        z3 = 32'd12345;
        z4 = 32'd12345;
    endtask

    // Straight transcription of the published LFSR113 recurrence.
    task automatic model_step(output logic [31:0] r);
        logic [31:0] b;
        b  = ((z1 << 6) ^ z1) >> 13;
        z1 = ((z1 & 32'hFFFFFFFE) << 18) ^ b;
        b  = ((z2 << 2) ^ z2) >> 27;
        z2 = ((z2 & 32'hFFFFFFF8) << 2) ^ b;
        b  = ((z3 << 13) ^ z3) >> 21;
        z3 = ((z3 & 32'hFFFFFFF0) << 7) ^ b;
        b  = ((z4 << 3) ^ z4) >> 12;
        z4 = ((z4 & 32'hFFFFFF80) << 13) ^ b;
        r  = z1 ^ z2 ^ z3 ^ z4;
    endtask

    initial begin
        logic [31:0] exp;

        // Reset and reseed on the same edge: reset must win.
        rst_n   = 1'b0;
        re_seed = 1'b1;
        seed    = 32'hDEADBEEF;
        tick();
        check("reset_rnd", rnd, 32'h00000000);
        check("reset_s1", dut.s1, 32'd12345);

        // Free run from the reset state.
        rst_n   = 1'b1;
        re_seed = 1'b0;
        model_seed(32'd12345);
        for (int i = 0; i < 10; i++) begin
            tick();
            model_step(exp);
            seq_rst[i] = exp;
            check("reset_run", rnd, exp);
        end
        check("reset_step1_const", seq_rst[0], 32'hC6F8D8AA);

        // Reseed 0xDEADBEEF: seed state visible right after the load edge.
        seed    = 32'hDEADBEEF;
        re_seed = 1'b1;
        tick();
        re_seed = 1'b0;
        check("db_load", rnd, 32'hDEAD8ED6);
        model_seed(32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            tick();
            model_step(exp);
            seq_db[i] = exp;
            check("db_run", rnd, exp);
        end
        check("db_step1_const", seq_db[0], 32'hFDA376DB);

        // Reseed 0xCAFEBABE.
        seed    = 32'hCAFEBABE;
        re_seed = 1'b1;
        tick();
        re_seed = 1'b0;
        check("cb_load", rnd, 32'hCAFE8A87);
        model_seed(32'hCAFEBABE);
        for (int i = 0; i < 10; i++) begin
            tick();
            model_step(exp);
            check("cb_run", rnd, exp);
        end

        // Second 0xDEADBEEF reseed at another stream position repeats exactly.
        for (int i = 0; i < 7; i++) tick();
        seed    = 32'hDEADBEEF;
        re_seed = 1'b1;
        tick();
        re_seed = 1'b0;
        check("db2_load", rnd, 32'hDEAD8ED6);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("db2_repeat", rnd, seq_db[i]);
        end

        // Illegal seeds 0 and 1 fall back to the default S1.
        for (int s = 0; s < 2; s++) begin
            seed    = 32'(s);
            re_seed = 1'b1;
            tick();
            re_seed = 1'b0;
            check("lowseed_s1", dut.s1, 32'd12345);
            check("lowseed_rnd", rnd, 32'h00000000);
            for (int i = 0; i < 5; i++) begin
                tick();
                check("lowseed_run", rnd, seq_rst[i]);
            end
        end

        // re_seed held three cycles freezes the output at the seed state.
        seed    = 32'h12345678;
        re_seed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", rnd, 32'h12346641);
        end
        re_seed = 1'b0;
        model_seed(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            tick();
            model_step(exp);
            check("hold_resume", rnd, exp);
        end

        // Mid-stream reset restarts the sequence from the beginning.
        rst_n = 1'b0;
        tick();
        check("mid_reset", rnd, 32'h00000000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_reset_run", rnd, seq_rst[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
